// File: rtl/prog_loader_mem.sv
// Program-image loader and 32x8 instruction store: streams 32 bytes into memory,
// then releases the CPU; fetch reads are combinational in every state.
module prog_loader_mem #(
  parameter bit BOOT_RUN = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] addr,
  output logic [7:0] data,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       load_done,
  output logic       cpu_run,
  output logic [5:0] load_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_mem [32];
  logic [5:0] r_count;
  logic [5:0] w_count_next;
  logic       r_done;
  logic       w_done_next;
  logic       w_wr;

  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_next       = S_LOAD;
          w_count_next = '0;
        end
      end
      S_LOAD: begin
        // A restart request takes priority over a byte offered in the same cycle.
        if (load_start) begin
          w_count_next = '0;
        end else if (load_valid) begin
          w_wr         = 1'b1;
          w_count_next = r_count + 6'd1;
          if (r_count == 6'd31) begin
            w_next      = S_RUN;
            w_done_next = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (load_start) begin
          w_next       = S_LOAD;
          w_count_next = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
      r_count <= '0;
      r_done  <= 1'b0;
      r_state <= BOOT_RUN ? S_RUN : S_IDLE;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
      if (w_wr) begin
        r_mem[r_count[4:0]] <= load_data;
      end
    end
  end

  assign data       = r_mem[addr];
  assign cpu_run    = (r_state == S_RUN);
  assign load_ready = (r_state == S_LOAD);
  assign load_done  = r_done;
  assign load_count = r_count;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Randomized self-checking bench for prog_loader_mem against a behavioural model.
module tb_prog_loader_mem;

  logic       clock;
  logic       reset;
  logic [4:0] addr;
  logic [7:0] data;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       cpu_run;
  logic [5:0] load_count;

  prog_loader_mem #(.BOOT_RUN(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .data       (data),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .cpu_run    (cpu_run),
    .load_count (load_count)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: image bytes, whether a load is in progress, whether the CPU runs.
  logic [7:0] m_mem [32];
  bit         m_loading;
  bit         m_running;
  int         m_count;
  bit         m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit st, input bit vl, input logic [7:0] d);
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_loading = 0;
      m_running = 0;
      m_count   = 0;
      m_done    = 0;
    end else begin
      m_done = 0;
      if (st) begin
        m_loading = 1;
        m_running = 0;
        m_count   = 0;
      end else if (m_loading && vl) begin
        m_mem[m_count] = d;
        m_count++;
        if (m_count == 32) begin
          m_loading = 0;
          m_running = 1;
          m_done    = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] a;
    check("cpu_run", cpu_run, m_running);
    check("load_ready", load_ready, m_loading);
    check("load_count", load_count, m_count);
    check("load_done", load_done, m_done);
    a = 5'($urandom);
    addr = a;
    #1;
    check("data_rand", data, m_mem[a]);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1;
      check(tag, data, m_mem[i]);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit vl, input logic [7:0] d);
    reset      = rst;
    load_start = st;
    load_valid = vl;
    load_data  = d;
    @(posedge clock);
    model_update(rst, st, vl, d);
    #1;
    reset      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [7:0] old5;
    logic [7:0] old10;
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0; addr = '0;

    // Reset with activity on the load inputs.
    step(1, 1, 1, 8'hA5);
    step(1, 0, 1, 8'h5A);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_ready", load_ready, 0);
    check("rst_count", load_count, 0);
    sweep("rst_zero");

    // Bytes offered while idle are ignored.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));

    // Back-to-back full load of 0..31.
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 8'(i));
    check("full_done", load_done, 1);
    check("full_cpu_run", cpu_run, 1);
    check("full_count", load_count, 32);
    addr = 5'h13;
    #1;
    check("full_addr13", data, 8'h13);
    sweep("full_img");
    step(0, 0, 0, 8'h00);
    check("done_one_cycle", load_done, 0);

    // Bytes offered in RUN are ignored.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));

    // Gapped load with alternating valid.
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 64; i++) step(0, 0, (i % 2) == 0, 8'($urandom));
    check("gap_count", load_count, 32);
    sweep("gap_img");

    // Mid-run reload: 5 bytes of FF.
    old5 = m_mem[5];
    step(0, 1, 0, 8'h00);
    check("reload_cpu_off", cpu_run, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'hFF);
    check("reload_count5", load_count, 5);
    addr = 5'd5;
    #1;
    check("reload_addr5_old", data, old5);
    for (int i = 0; i < 5; i++) begin
      addr = 5'(i);
      #1;
      check("reload_ff", data, 8'hFF);
    end

    // Advance to count 10, then restart with a byte in the same cycle.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom));
    old10 = m_mem[10];
    step(0, 1, 1, ~old10);
    check("restart_count", load_count, 0);
    addr = 5'd10;
    #1;
    check("restart_mem10", data, old10);

    // Reset at count 10 discards the partial image.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom));
    check("pre_rst_count", load_count, 10);
    step(1, 1, 1, 8'h77);
    check("midrst_cpu_run", cpu_run, 0);
    check("midrst_ready", load_ready, 0);
    sweep("midrst_zero");

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 300) == 0, ($urandom % 90) == 0,
           ($urandom % 4) != 0, 8'($urandom));
    end
    sweep("rand_img");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
